pixel_writeback_arbiter: RTL and testbench

//  Shares the GPU's single Avalon-MM write master (m1) among NUM_SHADERS shader

---
 rtl/pixel_writeback_arbiter_pkg.sv | 13 +
 rtl/pixel_writeback_arbiter_rr.sv | 33 +++
 rtl/pixel_writeback_arbiter.sv | 132 +++++++++++++
 tb/tb_pixel_writeback_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_writeback_arbiter_pkg.sv
// rtl/pixel_writeback_arbiter_pkg.sv - shared types for the pixel writeback arbiter
package pixel_writeback_arbiter_pkg;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } wb_state_t;

endpackage

// File: rtl/pixel_writeback_arbiter_rr.sv
// rtl/pixel_writeback_arbiter_rr.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return PW'(s);
    endfunction

    // Walk from farthest to nearest so the candidate closest to ptr wins last.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                grant_idx = wrap_idx(ptr, k);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_writeback_arbiter.sv
// rtl/pixel_writeback_arbiter.sv - drains masked shader pixels round-robin onto one write master
module pixel_writeback_arbiter
    import pixel_writeback_arbiter_pkg::*;
#(
    parameter int NUM_SHADERS    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_start,
    input  logic [NUM_SHADERS-1:0]    flush_mask,
    input  logic [NUM_SHADERS-1:0]    req_valid,
    input  logic [NUM_SHADERS*32-1:0] req_addr,
    input  logic [NUM_SHADERS*16-1:0] req_pixel,
    output logic [NUM_SHADERS-1:0]    req_ready,
    output logic [31:0]               m1_address,
    output logic [15:0]               m1_writedata,
    output logic                      m1_write,
    input  logic                      m1_waitrequest,
    output logic                      busy,
    output logic                      flush_done,
    output logic                      error,
    output logic [31:0]               error_addr
);

    localparam int PW = $clog2(NUM_SHADERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    wb_state_t state, next_state;

    logic [NUM_SHADERS-1:0]         pending, eligible, grant_oh, pending_after;
    logic [NUM_SHADERS-1:0][31:0]   addr_arr;
    logic [NUM_SHADERS-1:0][15:0]   pixel_arr;
    logic [PW-1:0]                  rr_ptr, grant, arb_idx, ptr_after;
    logic                           arb_any, beat_ok, timeout_hit, finish;
    logic [CW-1:0]                  wait_cnt;
    pixel_t                         sel_pixel;

    assign addr_arr  = req_addr;
    assign pixel_arr = req_pixel;
    assign eligible  = pending & req_valid;
    assign sel_pixel = pixel_arr[arb_idx];

    rr_arbiter #(.N(NUM_SHADERS)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign grant_oh      = NUM_SHADERS'(1) << grant;
    assign pending_after = pending & ~grant_oh;
    assign ptr_after     = (grant == PW'(NUM_SHADERS - 1)) ? '0 : grant + 1'b1;
    assign beat_ok       = (state == WRITE) && !m1_waitrequest;
    assign timeout_hit   = (state == WRITE) && m1_waitrequest &&
                           (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign finish        = beat_ok || timeout_hit;

    // The abort cycle withdraws the strobe so the stuck slave never sees a completed beat.
    assign m1_write   = (state == WRITE) && !timeout_hit;
    assign req_ready  = finish ? grant_oh : '0;
    assign flush_done = (state == DONE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (flush_start) next_state = (flush_mask == '0) ? DONE : SCAN;
            SCAN:    if (arb_any) next_state = WRITE;
            WRITE:   if (finish) next_state = (pending_after == '0) ? DONE : SCAN;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            rr_ptr       <= '0;
            grant        <= '0;
            wait_cnt     <= '0;
            m1_address   <= '0;
            m1_writedata <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            error_addr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_start) begin
                        pending    <= flush_mask;
                        error      <= 1'b0;
                        error_addr <= '0;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (arb_any) begin
                        grant        <= arb_idx;
                        m1_address   <= addr_arr[arb_idx];
                        m1_writedata <= sel_pixel;
                        wait_cnt     <= '0;
                    end
                end
                WRITE: begin
                    if (finish) begin
                        pending <= pending_after;
                        rr_ptr  <= ptr_after;
                        if (timeout_hit) begin
                            error <= 1'b1;
                            if (!error) begin
                                error_addr <= m1_address;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writeback_arbiter.sv
// tb/tb_pixel_writeback_arbiter.sv - directed scoreboard bench for pixel_writeback_arbiter
module tb_pixel_writeback_arbiter;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0800_0000;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [15:0] pix;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush_start = 1'b0;
    logic [N-1:0]    flush_mask = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_addr = '0;
    logic [N*16-1:0] req_pixel = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     m1_address;
    logic [15:0]     m1_writedata;
    logic            m1_write;
    logic            m1_waitrequest;
    logic            busy;
    logic            flush_done;
    logic            error;
    logic [31:0]     error_addr;

    logic [31:0] sh_addr [N];
    logic [15:0] sh_pix  [N];
    beat_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          stall_left = 0;
    int          wr_cycles = 0;
    int          stall_cycles = 0;
    logic [N-1:0] abort_mask = '0;

    pixel_writeback_arbiter #(.NUM_SHADERS(N), .TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_start    (flush_start),
        .flush_mask     (flush_mask),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_pixel      (req_pixel),
        .req_ready      (req_ready),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_waitrequest (m1_waitrequest),
        .busy           (busy),
        .flush_done     (flush_done),
        .error          (error),
        .error_addr     (error_addr)
    );

    always #5 clk = ~clk;

    function automatic logic unmapped(input logic [31:0] a);
        return (a < BASE) || (a >= BASE + 32'h0004_0000);
    endfunction

    assign m1_waitrequest = unmapped(m1_address) || (stall_left != 0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_shader(input int i, input logic [31:0] a, input logic [15:0] p);
        sh_addr[i]          = a;
        sh_pix[i]           = p;
        req_addr[i*32 +: 32] = a;
        req_pixel[i*16 +: 16] = p;
    endtask

    task automatic expect_beat(input int i);
        beat_t e;
        e.idx  = i;
        e.addr = sh_addr[i];
        e.pix  = sh_pix[i];
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        flush_mask  = mask;
        flush_start = 1'b1;
        @(posedge clk);
        #1;
        flush_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (flush_done !== 1'b1 && cyc < max_cyc);
        check(tag, flush_done, 1'b1);
    endtask

    // Slave model and scoreboard consumer
    initial begin : monitor
        logic        prev_stall;
        logic        dec;
        logic [31:0] hold_a;
        logic [15:0] hold_d;
        beat_t       e;
        prev_stall = 1'b0;
        hold_a     = '0;
        hold_d     = '0;
        forever begin
            @(negedge clk);
            dec = 1'b0;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (m1_write) begin
                    wr_cycles++;
                    if (prev_stall) begin
                        check("hold_addr", m1_address, hold_a);
                        check("hold_data", m1_writedata, hold_d);
                    end
                    if (m1_waitrequest) begin
                        stall_cycles++;
                        prev_stall = 1'b1;
                        hold_a     = m1_address;
                        hold_d     = m1_writedata;
                    end else begin
                        prev_stall = 1'b0;
                        if (sb.size() == 0) begin
                            check("unexpected_beat_addr", m1_address, 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            check("beat_addr", m1_address, e.addr);
                            check("beat_data", m1_writedata, e.pix);
                            check("beat_ready", req_ready, N'(1) << e.idx);
                        end
                    end
                    dec = (stall_left != 0);
                end else begin
                    prev_stall = 1'b0;
                end
                if (req_ready != '0 && !(m1_write && !m1_waitrequest)) begin
                    abort_mask = abort_mask | req_ready;
                end
                req_valid = req_valid & ~req_ready;
            end
            @(posedge clk);
            #1;
            if (dec) stall_left--;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m1_write", m1_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_error_addr", error_addr, 32'h0);
        check("rst_req_ready", req_ready, '0);
        check("rst_m1_address", m1_address, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty mask completes immediately
        pulse('0);
        @(negedge clk);
        check("mask0_done", flush_done, 1'b1);
        check("mask0_busy", busy, 1'b1);
        @(negedge clk);
        check("mask0_done_clr", flush_done, 1'b0);
        check("mask0_busy_clr", busy, 1'b0);

        // All eight shaders, round-robin from pointer 0
        for (int i = 0; i < N; i++) begin
            set_shader(i, BASE + 32'(2 * i), 16'(16'h1111 * (i + 1)));
            expect_beat(i);
        end
        req_valid = '1;
        pulse(8'hFF);
        wait_done("all8_done", 100, cyc);
        check("all8_cycles", cyc, 17);
        check("all8_drained", sb.size(), 0);
        check("all8_valid_left", req_valid, '0);
        @(negedge clk);
        check("all8_busy_clr", busy, 1'b0);

        // Fairness: only 3 and 5 valid, then the rest arrive later
        req_valid = 8'h28;
        expect_beat(3);
        expect_beat(5);
        pulse(8'hFF);
        cyc = 0;
        while (sb.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("fair_first_drained", sb.size(), 0);
        repeat (5) @(negedge clk);
        check("fair_hold_busy", busy, 1'b1);
        check("fair_hold_idle_bus", m1_write, 1'b0);
        foreach (sh_addr[i]) begin
            if (i != 3 && i != 5) begin
            end
        end
        expect_beat(6);
        expect_beat(7);
        expect_beat(0);
        expect_beat(1);
        expect_beat(2);
        expect_beat(4);
        @(posedge clk);
        #1;
        req_valid = req_valid | 8'hD7;
        wait_done("fair_done", 100, cyc);
        check("fair_drained", sb.size(), 0);

        // Single shader with first-write latency
        set_shader(0, BASE, 16'hF800);
        req_valid = 8'h01;
        expect_beat(0);
        pulse(8'h01);
        @(negedge clk);
        check("lat_cycle1", m1_write, 1'b0);
        @(negedge clk);
        check("lat_cycle2", m1_write, 1'b1);
        wait_done("single_done", 20, cyc);
        check("single_done_after_beat", cyc, 1);
        check("single_drained", sb.size(), 0);

        // Stall of 5 cycles; out-of-mask shader and re-arm while busy are ignored
        set_shader(0, BASE + 32'h100, 16'h1234);
        set_shader(1, BASE + 32'h102, 16'h5678);
        req_valid    = 8'h03;
        expect_beat(0);
        @(posedge clk);
        #1;
        stall_left   = 5;
        wr_cycles    = 0;
        stall_cycles = 0;
        pulse(8'h01);
        pulse(8'hFF);
        wait_done("stall_done", 40, cyc);
        check("stall_write_cycles", wr_cycles, 6);
        check("stall_stall_cycles", stall_cycles, 5);
        check("stall_no_error", error, 1'b0);
        check("stall_outside_mask", req_valid, 8'h02);
        repeat (4) @(negedge clk);
        check("busy_rearm_ignored", busy, 1'b0);
        check("stall_drained", sb.size(), 0);
        req_valid = '0;

        // Timeout on an unmapped address; pointer is at 1 after the last grant
        set_shader(0, BASE + 32'h10, 16'hAAAA);
        set_shader(1, BASE + 32'h12, 16'hBBBB);
        set_shader(2, 32'h0000_0010, 16'hCCCC);
        set_shader(3, BASE + 32'h16, 16'hDDDD);
        expect_beat(1);
        expect_beat(3);
        expect_beat(0);
        abort_mask   = '0;
        stall_cycles = 0;
        req_valid    = 8'h0F;
        pulse(8'h0F);
        wait_done("to_done", 300, cyc);
        check("to_error", error, 1'b1);
        check("to_error_addr", error_addr, 32'h10);
        check("to_stall_cycles", stall_cycles, 63);
        check("to_abort_mask", abort_mask, 8'h04);
        check("to_drained", sb.size(), 0);
        check("to_valid_left", req_valid, '0);

        // A new flush clears the sticky error
        pulse('0);
        @(negedge clk);
        check("clr_done", flush_done, 1'b1);
        check("clr_error", error, 1'b0);
        check("clr_error_addr", error_addr, 32'h0);

        // Reset during a stalled write drops the strobe at once
        set_shader(0, 32'h0000_0020, 16'h0F0F);
        req_valid = 8'h01;
        pulse(8'h01);
        @(negedge clk);
        @(negedge clk);
        check("rstw_writing", m1_write, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rstw_write_drop", m1_write, 1'b0);
        check("rstw_busy_drop", busy, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rstw_idle_write", m1_write, 1'b0);
        check("rstw_idle_ready", req_ready, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
